// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the x^4+x^3+1 pattern: hunts, verifies, locks and counts errors.
// Optional first-error capture ports are enabled by defining LFSR_SEQ_CHECKER_ERRLOG_EN.
module lfsr_seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [3:0]       data_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
`ifdef LFSR_SEQ_CHECKER_ERRLOG_EN
  output logic             first_err_valid,
  output logic [3:0]       first_err_rx,
  output logic [3:0]       first_err_exp,
`endif
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return {q[2:0], q[3] ^ q[2]};
  endfunction

  logic [1:0] state;
  logic [3:0] expected;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;
  logic       smp_match;
  logic       err_hit;

  always_comb begin
    smp_match = (data_in == expected);
    err_hit   = data_valid && (state == ST_LOCKED) && !smp_match;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HUNT;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      expected  <= 4'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
    end else begin
      err_pulse <= err_hit;
      // clear wins over the old value but a same-cycle error still counts
      if (err_clr)
        err_count <= err_hit ? ERR_W'(1) : '0;
      else if (err_hit && (err_count != '1))
        err_count <= err_count + ERR_W'(1);

      if (data_valid) begin
        case (state)
          ST_HUNT: begin
            if (data_in != 4'd0) begin
              expected  <= lfsr_next(data_in);
              match_cnt <= 4'd0;
              state     <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            if (data_in == 4'd0) begin
              state <= ST_HUNT;
            end else if (smp_match) begin
              expected <= lfsr_next(data_in);
              if (match_cnt == 4'(LOCK_CNT - 1)) begin
                match_cnt <= 4'd0;
                miss_cnt  <= 4'd0;
                state     <= ST_LOCKED;
                locked    <= 1'b1;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              expected  <= lfsr_next(data_in);
              match_cnt <= 4'd0;
            end
          end
          ST_LOCKED: begin
            // prediction free-runs so a corrupted sample cannot shift it
            expected <= lfsr_next(expected);
            if (smp_match) begin
              miss_cnt <= 4'd0;
            end else if (miss_cnt == 4'(LOSS_CNT - 1)) begin
              miss_cnt <= 4'd0;
              state    <= ST_HUNT;
              locked   <= 1'b0;
            end else begin
              miss_cnt <= miss_cnt + 4'd1;
            end
          end
          default: begin
            state  <= ST_HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_SEQ_CHECKER_ERRLOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      first_err_valid <= 1'b0;
      first_err_rx    <= 4'd0;
      first_err_exp   <= 4'd0;
    end else if (err_hit && (err_clr || !first_err_valid)) begin
      first_err_valid <= 1'b1;
      first_err_rx    <= data_in;
      first_err_exp   <= expected;
    end else if (err_clr) begin
      first_err_valid <= 1'b0;
      first_err_rx    <= 4'd0;
      first_err_exp   <= 4'd0;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker: two instances (ERR_W=16 and ERR_W=2) share stimulus.
module tb_lfsr_seq_checker;

  logic       clk = 1'b0;
  logic       reset, data_valid, err_clr;
  logic [3:0] data_in;
  logic       lk_a, pl_a, lk_b, pl_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
`ifdef LFSR_SEQ_CHECKER_ERRLOG_EN
  logic       fv_a, fv_b;
  logic [3:0] frx_a, fexp_a, frx_b, fexp_b;
`endif

  always #5 clk = ~clk;

  lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut_a (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in), .err_clr(err_clr),
    .locked(lk_a), .err_pulse(pl_a),
`ifdef LFSR_SEQ_CHECKER_ERRLOG_EN
    .first_err_valid(fv_a), .first_err_rx(frx_a), .first_err_exp(fexp_a),
`endif
    .err_count(cnt_a));

  lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) dut_b (
    .clk(clk), .reset(reset), .data_valid(data_valid), .data_in(data_in), .err_clr(err_clr),
    .locked(lk_b), .err_pulse(pl_b),
`ifdef LFSR_SEQ_CHECKER_ERRLOG_EN
    .first_err_valid(fv_b), .first_err_rx(frx_b), .first_err_exp(fexp_b),
`endif
    .err_count(cnt_b));

  // Sequence written out as a cycle of 15 values; the model walks it by position.
  logic [3:0] seq [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                           4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};

  function automatic logic [3:0] succ(input logic [3:0] v);
    for (int i = 0; i < 15; i++)
      if (seq[i] == v) return seq[(i + 1) % 15];
    return 4'd0;
  endfunction

  typedef struct {
    logic       lk;
    logic       pl;
    int         c16;
    int         c2;
    logic       fv;
    logic [3:0] frx;
    logic [3:0] fexp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // model state: 0 hunting, 1 verifying, 2 locked
  int         mode = 0;
  logic [3:0] mexp = 4'd0;
  int         nmatch = 0, nmiss = 0, c16 = 0, c2 = 0;
  logic       m_pl = 1'b0, m_fv = 1'b0;
  logic [3:0] m_frx = 4'd0, m_fexp = 4'd0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [3:0] d, input logic c);
    logic err;
    exp_t e;
    err = 1'b0;
    if (r) begin
      mode = 0; mexp = 4'd0; nmatch = 0; nmiss = 0; c16 = 0; c2 = 0;
      m_pl = 1'b0; m_fv = 1'b0; m_frx = 4'd0; m_fexp = 4'd0;
    end else begin
      if (v) begin
        if (mode == 0) begin
          if (d != 0) begin mexp = succ(d); nmatch = 0; mode = 1; end
        end else if (mode == 1) begin
          if (d == 0) mode = 0;
          else if (d == mexp) begin
            nmatch++; mexp = succ(d);
            if (nmatch == 4) begin mode = 2; nmiss = 0; end
          end else begin
            mexp = succ(d); nmatch = 0;
          end
        end else begin
          err = (d != mexp);
          if (err) begin
            if (c || !m_fv) begin m_fv = 1'b1; m_frx = d; m_fexp = mexp; end
            nmiss++;
            if (nmiss == 3) begin mode = 0; nmiss = 0; end
          end else nmiss = 0;
          mexp = succ(mexp);
        end
      end
      if (c) begin
        c16 = err ? 1 : 0; c2 = err ? 1 : 0;
        if (!err) begin m_fv = 1'b0; m_frx = 4'd0; m_fexp = 4'd0; end
      end else if (err) begin
        if (c16 < 65535) c16++;
        if (c2 < 3) c2++;
      end
      m_pl = err;
    end
    e.lk = (mode == 2); e.pl = m_pl; e.c16 = c16; e.c2 = c2;
    e.fv = m_fv; e.frx = m_frx; e.fexp = m_fexp;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic v, input logic [3:0] d, input logic c);
    @(negedge clk);
    reset = r; data_valid = v; data_in = d; err_clr = c;
    model_step(r, v, d, c);
  endtask

  task automatic send(input logic [3:0] d);
    cyc(1'b0, 1'b1, d, 1'b0);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, 4'($urandom), 1'b0);
  endtask
  task automatic do_reset();
    cyc(1'b1, 1'($urandom), 4'($urandom), 1'($urandom));
  endtask
  task automatic send_bad();
    send(mexp ^ 4'(1 + $urandom % 15));
  endtask
  task automatic lock_seq();
    send(4'd1); send(4'd2); send(4'd4); send(4'd9); send(4'd3);
  endtask
  // waits for the edge that consumes the last driven inputs
  task automatic settle();
    @(posedge clk); #2;
  endtask

  // monitor: every edge the DUTs present a new output set
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("locked_a", int'(lk_a), int'(e.lk));
      chk("locked_b", int'(lk_b), int'(e.lk));
      chk("err_pulse_a", int'(pl_a), int'(e.pl));
      chk("err_pulse_b", int'(pl_b), int'(e.pl));
      chk("err_count_a", int'(cnt_a), e.c16);
      chk("err_count_b", int'(cnt_b), e.c2);
`ifdef LFSR_SEQ_CHECKER_ERRLOG_EN
      chk("first_err_valid_a", int'(fv_a), int'(e.fv));
      chk("first_err_rx_a", int'(frx_a), int'(e.frx));
      chk("first_err_exp_a", int'(fexp_a), int'(e.fexp));
      chk("first_err_valid_b", int'(fv_b), int'(e.fv));
      chk("first_err_rx_b", int'(frx_b), int'(e.frx));
      chk("first_err_exp_b", int'(fexp_b), int'(e.fexp));
`endif
    end
  end

  initial begin
    reset = 1'b1; data_valid = 1'b0; data_in = 4'd0; err_clr = 1'b0;

    do_reset(); do_reset(); settle();
    chk("reset_locked", int'(lk_a), 0);
    chk("reset_count", int'(cnt_a), 0);

    lock_seq(); settle();
    chk("lock_direct", int'(lk_a), 1);

    do_reset();
    send(4'd1); idle(); send(4'd2); idle(); idle(); send(4'd4); idle();
    send(4'd9); idle(); send(4'd3); settle();
    chk("lock_gaps", int'(lk_a), 1);

    send(4'd7); send(4'd13); send(4'd10); settle();
    chk("single_err_count", int'(cnt_a), 1);
    chk("single_err_locked", int'(lk_a), 1);

    do_reset(); lock_seq();
    send(4'd0); send(4'd0); send(4'd0); settle();
    chk("loss_count", int'(cnt_a), 3);
    chk("loss_locked", int'(lk_a), 0);
    send(4'd8); send(4'd1); send(4'd2); send(4'd4); send(4'd9); settle();
    chk("relock", int'(lk_a), 1);

    do_reset();
    send(4'd0); send(4'd0); send(4'd5); send(4'd11); send(4'd7); send(4'd15); send(4'd14);
    settle();
    chk("hunt_lock", int'(lk_a), 1);

    do_reset();
    send(4'd5); send(4'd11); send(4'd2); send(4'd4); send(4'd9); send(4'd3);
    settle();
    chk("reseed_not_yet", int'(lk_a), 0);
    send(4'd6); settle();
    chk("reseed_lock", int'(lk_a), 1);

    do_reset(); lock_seq();
    send(4'd7); send(mexp); settle();
`ifdef LFSR_SEQ_CHECKER_ERRLOG_EN
    chk("log_valid", int'(fv_a), 1);
    chk("log_rx", int'(frx_a), 7);
    chk("log_exp", int'(fexp_a), 6);
`endif
    for (int i = 0; i < 4; i++) begin send_bad(); send(mexp); end
    settle();
    chk("sat_count_b", int'(cnt_b), 3);
    chk("sat_count_a", int'(cnt_a), 5);
    chk("sat_locked", int'(lk_a), 1);
    cyc(1'b0, 1'b1, mexp ^ 4'd3, 1'b1); settle();
    chk("clr_err_a", int'(cnt_a), 1);
    chk("clr_err_b", int'(cnt_b), 1);
    cyc(1'b0, 1'b0, 4'd0, 1'b1); settle();
    chk("clr_only", int'(cnt_a), 0);
`ifdef LFSR_SEQ_CHECKER_ERRLOG_EN
    chk("log_cleared", int'(fv_a), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic       r, v, c;
      logic [3:0] d;
      r = ($urandom % 200) == 0;
      v = ($urandom % 4) != 0;
      c = ($urandom % 40) == 0;
      if (mode != 0 && ($urandom % 100) < 85) d = mexp;
      else d = 4'($urandom);
      cyc(r, v, d, c);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
